// File: rtl/videoram_rd_arbiter.sv
// videoram_rd_arbiter: shares one videoram read port between requesters A and B,
// tagging each issued read so its data returns to the requester that asked for it.
module videoram_rd_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ROUND_ROBIN  = 0,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              b_forced
);
    localparam int WC_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);
    logic [WC_W-1:0] wait_cnt;
    logic last_b;
    logic force_b;
    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_b;
    logic exit_a;
    logic exit_b;
    always_comb begin
        force_b = a_req && b_req && (MAX_WAIT != 0) && (wait_cnt == WAIT_MAX);
        b_gnt   = b_req && (!a_req || force_b || (ROUND_ROBIN != 0 && !last_b));
        a_gnt   = a_req && !b_gnt;
        exit_a  = tag_v[READ_LATENCY-1] && !tag_b[READ_LATENCY-1];
        exit_b  = tag_v[READ_LATENCY-1] && tag_b[READ_LATENCY-1];
    end
    // The rvalid/rdata flops form the final stage of the tag pipe, so mem_rdata is
    // captured at the edge that completes READ_LATENCY cycles of mem_addr being valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            tag_v    <= '0;
            tag_b    <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            b_forced <= 1'b0;
            wait_cnt <= '0;
            last_b   <= 1'b1;
        end else begin
            if (a_gnt || b_gnt) begin
                mem_addr <= b_gnt ? b_addr : a_addr;
                last_b   <= b_gnt;
            end
            tag_v    <= READ_LATENCY'({tag_v, a_gnt || b_gnt});
            tag_b    <= READ_LATENCY'({tag_b, b_gnt});
            a_rvalid <= exit_a;
            b_rvalid <= exit_b;
            if (exit_a) a_rdata <= mem_rdata;
            if (exit_b) b_rdata <= mem_rdata;
            b_forced <= force_b;
            wait_cnt <= b_gnt ? '0 :
                        (ROUND_ROBIN == 0 && b_req && wait_cnt != WAIT_MAX) ? wait_cnt + 1'b1 :
                        wait_cnt;
        end
    end
endmodule

// File: tb/tb_videoram_rd_arbiter.sv
// tb_videoram_rd_arbiter: three arbiter configurations driven by shared directed stimulus,
// each with a reference arbiter, memory model and return scoreboard.
module tb_videoram_rd_arbiter;
    typedef struct {
        int          due;
        logic [31:0] d;
    } ret_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_req = 1'b0;
    logic b_req = 1'b0;
    logic [11:0] a_addr = '0;
    logic [11:0] b_addr = '0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [11:0] a);
        return {a, ~a, 8'h5A};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic ar, input logic [11:0] aa, input logic br, input logic [11:0] ba);
        a_req = ar;
        a_addr = aa;
        b_req = br;
        b_addr = ba;
        @(posedge clk);
        #1;
    endtask

    genvar g;
    for (g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 2) ? 4 : 1;
        localparam int R = (g == 1) ? 1 : 0;
        logic a_gnt, a_rvalid, b_gnt, b_rvalid, b_forced;
        logic [31:0] a_rdata, b_rdata, mem_rdata;
        logic [11:0] mem_addr;
        logic [11:0] hist [1:4];
        ret_t qa[$];
        ret_t qb[$];
        int wc = 0, na = 0, nb = 0, nga = 0, ngb = 0, nbf = 0;
        logic lastb = 1'b1, pf = 1'b0, ea, eb, fb, va, vb;
        logic [31:0] la = '0, lb = '0;

        videoram_rd_arbiter #(
            .ADDR_W(12), .DATA_W(32), .READ_LATENCY(L), .ROUND_ROBIN(R), .MAX_WAIT(15)
        ) u (
            .clk(clk), .reset(reset),
            .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
            .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
            .mem_addr(mem_addr), .mem_rdata(mem_rdata), .b_forced(b_forced)
        );

        // Memory answers READ_LATENCY cycles after the address edge.
        always @(posedge clk) begin
            hist[1] <= mem_addr;
            for (int k = 2; k <= 4; k++) hist[k] <= hist[k-1];
        end
        assign mem_rdata = (L == 1) ? word(mem_addr) : word(hist[(L > 1) ? L - 1 : 1]);

        always @(negedge clk) begin
            if (reset) begin
                qa.delete();
                qb.delete();
                wc = 0;
                lastb = 1'b1;
                pf = 1'b0;
                la = '0;
                lb = '0;
                check($sformatf("i%0d reset flags", g), {a_rvalid, b_rvalid, b_forced, a_gnt, b_gnt}, 0);
                check($sformatf("i%0d reset mem_addr", g), mem_addr, 0);
                check($sformatf("i%0d reset rdata", g), a_rdata | b_rdata, 0);
                check($sformatf("i%0d reset wait_cnt", g), u.wait_cnt, 0);
            end else begin
                fb = a_req && b_req && wc == 15;
                eb = b_req && (!a_req || fb || (R == 1 && !lastb));
                ea = a_req && !eb;
                check($sformatf("i%0d gnt", g), {a_gnt, b_gnt}, {ea, eb});
                check($sformatf("i%0d b_forced", g), b_forced, pf);
                check($sformatf("i%0d wait_cnt", g), u.wait_cnt, wc);
                va = (qa.size() > 0) ? (qa[0].due == cyc) : 1'b0;
                vb = (qb.size() > 0) ? (qb[0].due == cyc) : 1'b0;
                check($sformatf("i%0d rvalid", g), {a_rvalid, b_rvalid}, {va, vb});
                if (va) begin
                    la = qa[0].d;
                    void'(qa.pop_front());
                end
                if (vb) begin
                    lb = qb[0].d;
                    void'(qb.pop_front());
                end
                check($sformatf("i%0d a_rdata", g), a_rdata, la);
                check($sformatf("i%0d b_rdata", g), b_rdata, lb);
                if (a_rvalid) na++;
                if (b_rvalid) nb++;
                if (a_gnt) nga++;
                if (b_gnt) ngb++;
                if (b_forced) nbf++;
                if (ea) qa.push_back('{cyc + 1 + L, word(a_addr)});
                if (eb) qb.push_back('{cyc + 1 + L, word(b_addr)});
                if (ea || eb) lastb = eb;
                pf = eb && fb;
                wc = eb ? 0 : (R == 0 && b_req) ? ((wc == 15) ? 15 : wc + 1) : wc;
            end
        end
    end

    int s0, s1, s2, t0, t1, t2;

    initial begin
        repeat (3) drive(0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0);
        // A alone, one new address per cycle
        for (int i = 0; i < 16; i++) drive(1, 12'h010 + 12'(i), 0, 0);
        repeat (8) drive(0, 0, 0, 0);
        check("t1 i0 a grants", gi[0].nga, 16);
        check("t1 i0 a returns", gi[0].na, 16);
        check("t1 i2 a returns", gi[2].na, 16);
        // Continuous contention
        s0 = gi[0].ngb; s1 = gi[1].ngb; s2 = gi[2].ngb;
        t0 = gi[0].nga; t1 = gi[1].nga;
        for (int i = 0; i < 40; i++) drive(1, 12'h100 + 12'(i), 1, 12'h200 + 12'(i));
        repeat (8) drive(0, 0, 0, 0);
        check("t3 i0 b grants", gi[0].ngb - s0, 2);
        check("t3 i0 a grants", gi[0].nga - t0, 38);
        check("t3 i0 b_forced", gi[0].nbf, 2);
        check("t3 i2 b grants", gi[2].ngb - s2, 2);
        check("t2 i1 b grants", gi[1].ngb - s1, 20);
        check("t2 i1 a grants", gi[1].nga - t1, 20);
        check("t2 i1 b_forced", gi[1].nbf, 0);
        check("t2 i1 b returns", gi[1].nb, 20);
        check("t3 i2 b returns", gi[2].nb, 2);
        // B pulse while A holds
        drive(0, 0, 1, 12'h300);
        s0 = gi[0].ngb;
        drive(1, 12'h400, 1, 12'h301);
        for (int i = 1; i < 4; i++) drive(1, 12'h400 + 12'(i), 0, 0);
        repeat (8) drive(0, 0, 0, 0);
        check("t5 i0 wait_cnt", gi[0].u.wait_cnt, 1);
        check("t5 i0 b grants", gi[0].ngb - s0, 0);
        check("t5 i0 b returns", gi[0].nb, gi[0].ngb);
        // Reset with two reads in flight on the latency-4 instance
        s2 = gi[2].na + gi[2].nb;
        drive(1, 12'h500, 0, 0);
        drive(0, 0, 1, 12'h501);
        reset = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        repeat (8) drive(0, 0, 0, 0);
        check("t4 i2 no returns", gi[2].na + gi[2].nb - s2, 0);
        check("t4 i2 a_rdata", gi[2].a_rdata, 0);
        check("t4 i2 mem_addr", gi[2].mem_addr, 0);
        // Random traffic
        s0 = gi[0].nga + gi[0].ngb - gi[0].na - gi[0].nb;
        s1 = gi[1].nga + gi[1].ngb - gi[1].na - gi[1].nb;
        s2 = gi[2].nga + gi[2].ngb - gi[2].na - gi[2].nb;
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)), 12'($urandom));
        repeat (10) drive(0, 0, 0, 0);
        check("t6 i0 grants returned", gi[0].nga + gi[0].ngb - gi[0].na - gi[0].nb, s0);
        check("t6 i1 grants returned", gi[1].nga + gi[1].ngb - gi[1].na - gi[1].nb, s1);
        check("t6 i2 grants returned", gi[2].nga + gi[2].ngb - gi[2].na - gi[2].nb, s2);
        check("t6 i2 queues empty", gi[2].qa.size() + gi[2].qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
